sr_flag_bank: RTL and testbench
===============================

# sr_flag_bank

Parametrised, synchronous successor to the gate-level cross-coupled NAND SR latch. It holds CH independent SR flags. Each flag has NS active-low set and NS active-low reset inputs, a programmable set/reset conflict policy, and a per-channel lockout counter that enforces a minimum hold time after each state change. It sits between raw control/status strobes and downstream logic that needs glitch-free, rate-limited flags with complementary outputs.

## Interface
- CH, 4, number of flag channels (1..32)
- NS, 2, active-low set inputs and active-low reset inputs per channel (1..8)
- HOLD_CYC, 3, cycles a flag is locked after it changes; 0 disables lockout
- MODE, 0, conflict policy for simultaneous set and reset: 0 = reset wins, 1 = set wins, 2 = hold, 3 = toggle
- RST_VAL, 0, reset value of every flag (0 or 1)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- set_n  in  CH*NS  active-low set requests; channel c uses bits [c*NS +: NS]
- rst_flag_n  in  CH*NS  active-low reset requests; same packing as set_n
- conflict_clr  in  1  clears all sticky conflict bits
- q  out  CH  flag state
- q_n  out  CH  always exactly ~q; no invalid state
- changed  out  CH  one-cycle pulse in the cycle after q changes
- locked  out  CH  lockout counter of the channel is non-zero
- conflict  out  CH  sticky; set when set and reset requests coincide

## Operation
- Per channel: set_req = any set_n bit low; clr_req = any rst_flag_n bit low. This matches the multi-input NAND latch semantics.
- Next-state when not locked:
  - set_req only: 1
  - clr_req only: 0
  - neither: hold
  - both: resolved by MODE (0 → 0, 1 → 1, 2 → hold, 3 → ~q)
- When locked (counter ≠ 0), all requests are ignored and q holds. Conflicts are still recorded in conflict.
- On every q change, the counter loads HOLD_CYC. Otherwise a non-zero counter decrements by 1 each cycle. Counter width is $clog2(HOLD_CYC+1); it saturates at 0 and never wraps.
- A request that would not change q (e.g. set while q = 1) does not load the counter and does not pulse changed.
- conflict[c] sets on any cycle with set_req and clr_req both true, including locked cycles. It clears only on conflict_clr or reset. If conflict_clr and a new conflict occur in the same cycle, the set wins (bit reads 1).
- Channels are fully independent. There is no cross-channel priority.

## Timing
- All outputs are registered. Request in cycle n → q updated at edge n+1 (1-cycle latency).
- changed is a registered pulse, high for exactly the cycle following the q update. It cannot re-pulse for HOLD_CYC cycles.
- With HOLD_CYC = H, after a change at edge n the next change is possible at edge n+H+1 at the earliest. locked is high for H cycles after the change.
- Reset (rst_n low at an edge):
  - q = RST_VAL, q_n = ~RST_VAL
  - changed = 0, locked = 0, conflict = 0
  - counters = 0
- Reset mid-lockout aborts the lockout. The first edge after rst_n rises accepts requests.
- Inputs are sampled only at the clock edge. Pulses between edges are not captured, and no asynchronous path exists.

## Structure
- Package sr_pkg holds:
  - MODE constants: SR_RESET_WINS = 0, SR_SET_WINS = 1, SR_HOLD = 2, SR_TOGGLE = 3
  - a typedef for the mode field
- One sub-module, sr_channel, holds a single flag, its lockout counter, changed register and conflict bit. It is instantiated CH times in a generate loop.
- The top level only slices the input vectors and reduces each channel's NS bits to set_req and clr_req.

## Test plan
- Reset with RST_VAL = 1, then release → q = all 1, q_n = all 0, changed/locked/conflict = 0.
- CH=4, NS=2, HOLD_CYC=0. Drive set_n[1] low (channel 0, input 1) for one cycle → q[0] = 1 one edge later, changed[0] pulses once. Other channels are unchanged.
- MODE = 0, 1, 2, 3 in turn, with both set and reset asserted on channel 2 while q[2] = 1 → q[2] = 0, 1, 1, 0 respectively, and conflict[2] = 1 sticky until conflict_clr.
- HOLD_CYC=3. Set channel 3, then assert reset on every cycle → q[3] = 1 and locked[3] = 1 for 3 cycles. q[3] = 0 on the 4th edge after the set.
- Reset asserted during lockout (counter = 2) → locked = 0 and q = RST_VAL. A set on the first cycle after release takes effect immediately.
- conflict_clr asserted in the same cycle as a new conflict on channel 1 → conflict[1] reads 1. Asserting conflict_clr alone on the next cycle → 0.

Source files
------------

// File: rtl/sr_flag_bank_pkg.sv
// Shared types for the SR flag bank: conflict-policy encoding and counter sizing.
package sr_pkg;

    // Policy applied when set and reset requests arrive on the same edge.
    typedef enum logic [1:0] {
        SR_RESET_WINS = 2'd0,
        SR_SET_WINS   = 2'd1,
        SR_HOLD       = 2'd2,
        SR_TOGGLE     = 2'd3
    } sr_mode_t;

    // Lockout counter width; a zero hold time still needs a 1-bit counter.
    function automatic int sr_cnt_w(input int hold);
        return (hold <= 0) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/sr_flag_bank_if.sv
// Request/response bundle for the SR flag bank.
interface sr_flag_bank_if #(
    parameter int CH = 4,
    parameter int NS = 2
);
    logic [CH*NS-1:0] set_n;
    logic [CH*NS-1:0] rst_flag_n;
    logic             conflict_clr;
    logic [CH-1:0]    q;
    logic [CH-1:0]    q_n;
    logic [CH-1:0]    changed;
    logic [CH-1:0]    locked;
    logic [CH-1:0]    conflict;

    modport master (
        output set_n, rst_flag_n, conflict_clr,
        input  q, q_n, changed, locked, conflict
    );

    modport slave (
        input  set_n, rst_flag_n, conflict_clr,
        output q, q_n, changed, locked, conflict
    );
endinterface

// File: rtl/sr_channel.sv
// One flag: SR state with conflict policy, post-change lockout, change pulse
// and sticky conflict bit.
module sr_channel
    import sr_pkg::*;
#(
    parameter int HOLD_CYC = 3,
    parameter int MODE     = 0,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic conflict_clr,
    output logic q,
    output logic q_n,
    output logic changed,
    output logic locked,
    output logic conflict
);
    localparam int            CW      = sr_cnt_w(HOLD_CYC);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);
    localparam sr_mode_t      MODE_E  = sr_mode_t'(MODE[1:0]);

    logic          q_r;
    logic          nxt;
    logic [CW-1:0] cnt;

    // Requested next state, ignoring lockout.
    always_comb begin
        nxt = q_r;
        if (set_req && clr_req) begin
            case (MODE_E)
                SR_RESET_WINS: nxt = 1'b0;
                SR_SET_WINS:   nxt = 1'b1;
                SR_HOLD:       nxt = q_r;
                SR_TOGGLE:     nxt = ~q_r;
                default:       nxt = q_r;
            endcase
        end else if (set_req) begin
            nxt = 1'b1;
        end else if (clr_req) begin
            nxt = 1'b0;
        end
    end

    // Flag, lockout counter, change pulse and sticky conflict update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r      <= RST_VAL;
            cnt      <= '0;
            changed  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (nxt != q_r) begin
                // Only a real change reloads the lockout and pulses changed.
                q_r     <= nxt;
                cnt     <= HOLD_LD;
                changed <= 1'b1;
            end
            // New conflict outranks a simultaneous clear.
            conflict <= (set_req && clr_req) || (conflict && !conflict_clr);
        end
    end

    assign q      = q_r;
    assign q_n    = ~q_r;
    assign locked = (cnt != '0);

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of CH independent SR flags; slices the request vectors and reduces
// each channel's active-low inputs to a single set/clear request.
module sr_flag_bank
    import sr_pkg::*;
#(
    parameter int CH       = 4,
    parameter int NS       = 2,
    parameter int HOLD_CYC = 3,
    parameter int MODE     = 0,
    parameter bit RST_VAL  = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    sr_flag_bank_if.slave bus
);
    logic [CH-1:0] q_v;
    logic [CH-1:0] q_n_v;
    logic [CH-1:0] changed_v;
    logic [CH-1:0] locked_v;
    logic [CH-1:0] conflict_v;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic set_req;
        logic clr_req;

        // Any low input asserts the request, like a multi-input NAND latch.
        assign set_req = ~&bus.set_n[c*NS +: NS];
        assign clr_req = ~&bus.rst_flag_n[c*NS +: NS];

        sr_channel #(
            .HOLD_CYC (HOLD_CYC),
            .MODE     (MODE),
            .RST_VAL  (RST_VAL)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .set_req      (set_req),
            .clr_req      (clr_req),
            .conflict_clr (bus.conflict_clr),
            .q            (q_v[c]),
            .q_n          (q_n_v[c]),
            .changed      (changed_v[c]),
            .locked       (locked_v[c]),
            .conflict     (conflict_v[c])
        );
    end

    assign bus.q        = q_v;
    assign bus.q_n      = q_n_v;
    assign bus.changed  = changed_v;
    assign bus.locked   = locked_v;
    assign bus.conflict = conflict_v;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Scoreboard bench for sr_flag_bank. Six configurations share one stimulus
// bus: 0 = RST_VAL 1; 1..4 = MODE 0..3; 5 = HOLD_CYC 3. All CH=4, NS=2.
module tb_sr_flag_bank;
    localparam int NI = 6;
    localparam logic [7:0] IDLE = 8'hFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] set_n = IDLE;
    logic [7:0] rst_flag_n = IDLE;
    logic conflict_clr = 1'b0;
    int cyc = 0;

    logic [3:0] q_a   [NI];
    logic [3:0] qn_a  [NI];
    logic [3:0] chg_a [NI];
    logic [3:0] lk_a  [NI];
    logic [3:0] cf_a  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam bit RV = (i == 0);
        localparam int MD = (i >= 1 && i <= 4) ? i - 1 : 0;
        localparam int HC = (i == 5) ? 3 : 0;
        sr_flag_bank_if #(.CH(4), .NS(2)) bus ();
        assign bus.set_n        = set_n;
        assign bus.rst_flag_n   = rst_flag_n;
        assign bus.conflict_clr = conflict_clr;
        sr_flag_bank #(.CH(4), .NS(2), .HOLD_CYC(HC), .MODE(MD), .RST_VAL(RV)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign q_a[i]   = bus.q;
        assign qn_a[i]  = bus.q_n;
        assign chg_a[i] = bus.changed;
        assign lk_a[i]  = bus.locked;
        assign cf_a[i]  = bus.conflict;
    end

    typedef struct {
        int         cyc;
        int         inst;
        string      name;
        logic [3:0] q;
        logic [3:0] chg;
        logic [3:0] lk;
        logic [3:0] cf;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;

    // Monitor: compare every expectation due at or before the current edge.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            vectors++;
            if (e.cyc != cyc ||
                q_a[e.inst] !== e.q || qn_a[e.inst] !== ~e.q ||
                chg_a[e.inst] !== e.chg || lk_a[e.inst] !== e.lk ||
                cf_a[e.inst] !== e.cf) begin
                miscompares++;
                $display("FAIL %s inst%0d cyc%0d: got q=%b qn=%b chg=%b lk=%b cf=%b, want q=%b qn=%b chg=%b lk=%b cf=%b",
                         e.name, e.inst, cyc, q_a[e.inst], qn_a[e.inst], chg_a[e.inst],
                         lk_a[e.inst], cf_a[e.inst], e.q, ~e.q, e.chg, e.lk, e.cf);
            end
        end
    end

    // Drive one cycle of inputs; they are sampled at the next rising edge.
    task automatic step(input logic [7:0] sn, input logic [7:0] rn,
                        input logic cc, input logic rstn);
        @(negedge clk);
        set_n        = sn;
        rst_flag_n   = rn;
        conflict_clr = cc;
        rst_n        = rstn;
    endtask

    // Expected outputs of one instance after the edge following the last step.
    task automatic chk(input int inst, input string nm, input logic [3:0] q,
                       input logic [3:0] chg, input logic [3:0] lk, input logic [3:0] cf);
        exp_t x;
        x.cyc = cyc + 1; x.inst = inst; x.name = nm;
        x.q = q; x.chg = chg; x.lk = lk; x.cf = cf;
        sbq.push_back(x);
    endtask

    initial begin
        // Reset values, RST_VAL = 1 and 0.
        step(IDLE, IDLE, 1'b0, 1'b0);
        chk(0, "rst_q1", 4'hF, 4'h0, 4'h0, 4'h0);
        chk(5, "rst_q0", 4'h0, 4'h0, 4'h0, 4'h0);
        step(IDLE, IDLE, 1'b0, 1'b1);
        chk(0, "rel_q1", 4'hF, 4'h0, 4'h0, 4'h0);

        // Single set on channel 0 via input 1; redundant set is a no-op.
        step(8'hFD, IDLE, 1'b0, 1'b1);
        chk(1, "set_ch0", 4'h1, 4'h1, 4'h0, 4'h0);
        chk(0, "set_noop", 4'hF, 4'h0, 4'h0, 4'h0);
        step(IDLE, IDLE, 1'b0, 1'b1);
        chk(1, "set_ch0_hold", 4'h1, 4'h0, 4'h0, 4'h0);

        // Conflict policy on channel 2 with q[2] = 1.
        step(IDLE, IDLE, 1'b0, 1'b0);
        step(8'hEF, IDLE, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) chk(i, "pre_ch2", 4'h4, 4'h4, 4'h0, 4'h0);
        step(8'hEF, 8'hEF, 1'b0, 1'b1);
        chk(1, "mode_reset", 4'h0, 4'h4, 4'h0, 4'h4);
        chk(2, "mode_set",   4'h4, 4'h0, 4'h0, 4'h4);
        chk(3, "mode_hold",  4'h4, 4'h0, 4'h0, 4'h4);
        chk(4, "mode_tog",   4'h0, 4'h4, 4'h0, 4'h4);
        step(IDLE, IDLE, 1'b0, 1'b1);
        chk(1, "cf_sticky0", 4'h0, 4'h0, 4'h0, 4'h4);
        chk(4, "cf_sticky3", 4'h0, 4'h0, 4'h0, 4'h4);
        step(IDLE, IDLE, 1'b1, 1'b1);
        chk(1, "cf_clr0", 4'h0, 4'h0, 4'h0, 4'h0);
        chk(2, "cf_clr1", 4'h4, 4'h0, 4'h0, 4'h0);

        // Lockout: set channel 3, then hold reset requests.
        step(IDLE, IDLE, 1'b0, 1'b0);
        step(IDLE, IDLE, 1'b0, 1'b1);
        step(8'hBF, IDLE, 1'b0, 1'b1);
        chk(5, "lk_set", 4'h8, 4'h8, 4'h8, 4'h0);
        for (int k = 0; k < 3; k++) begin
            step(IDLE, 8'hBF, 1'b0, 1'b1);
            chk(5, "lk_hold", 4'h8, 4'h0, (k < 2) ? 4'h8 : 4'h0, 4'h0);
        end
        step(IDLE, 8'hBF, 1'b0, 1'b1);
        chk(5, "lk_clr", 4'h0, 4'h8, 4'h8, 4'h0);

        // Reset mid-lockout, then immediate set after release.
        step(IDLE, IDLE, 1'b0, 1'b0);
        step(IDLE, IDLE, 1'b0, 1'b1);
        step(8'hBF, IDLE, 1'b0, 1'b1);
        chk(5, "lk2_set", 4'h8, 4'h8, 4'h8, 4'h0);
        step(IDLE, IDLE, 1'b0, 1'b1);
        chk(5, "lk2_cnt2", 4'h8, 4'h0, 4'h8, 4'h0);
        step(IDLE, IDLE, 1'b0, 1'b0);
        chk(5, "lk_abort", 4'h0, 4'h0, 4'h0, 4'h0);
        step(8'hBF, IDLE, 1'b0, 1'b1);
        chk(5, "post_rst_set", 4'h8, 4'h8, 4'h8, 4'h0);
        step(8'hBF, 8'hBF, 1'b0, 1'b1);
        chk(5, "lk_conflict", 4'h8, 4'h0, 4'h8, 4'h8);

        // conflict_clr racing a new conflict on channel 1.
        step(IDLE, IDLE, 1'b0, 1'b0);
        step(8'hFB, 8'hFB, 1'b1, 1'b1);
        chk(1, "cf_race", 4'h0, 4'h0, 4'h0, 4'h2);
        step(IDLE, IDLE, 1'b1, 1'b1);
        chk(1, "cf_clr_only", 4'h0, 4'h0, 4'h0, 4'h0);
        step(IDLE, IDLE, 1'b0, 1'b1);

        for (int t = 0; t < 20 && sbq.size() > 0; t++) @(negedge clk);
        while (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s inst%0d: never checked (due cyc%0d)", x.name, x.inst, x.cyc);
        end

        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (qn_a[i] !== ~q_a[i]) begin
                miscompares++;
                $display("FAIL final_qn inst%0d: q=%b qn=%b", i, q_a[i], qn_a[i]);
            end
        end
        vectors++;
        if (q_a[1] !== 4'h0) begin
            miscompares++;
            $display("FAIL final_q inst1: q=%b", q_a[1]);
        end
        vectors++;
        if (cf_a[1] !== 4'h0) begin
            miscompares++;
            $display("FAIL final_cf inst1: cf=%b", cf_a[1]);
        end
        vectors++;
        if (lk_a[5] !== 4'h0) begin
            miscompares++;
            $display("FAIL final_lk inst5: lk=%b", lk_a[5]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
